// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Returned {instr, pc} pairs are queued in a small FIFO towards decode.
module fetch_pc_unit #(
    parameter int unsigned      ADDR_W     = 32,
    parameter int unsigned      INSTR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fetch_enable,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  estado_pc,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    input  logic               dec_ready
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    entry_t             fifo_q [FIFO_DEPTH];
    entry_t             fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               has_room;
    logic               req_valid;
    logic               req_fire;
    logic               push;
    logic               pop;
    logic               head_valid;

    // Issue only with a guaranteed free slot so a response can always be queued.
    always_comb begin
        has_room   = (count_q < DEPTH_CNT);
        head_valid = (count_q != '0);
        req_valid  = (state_q == ST_REQ) && has_room && !redirect_valid;
        req_fire   = req_valid && imem_req_ready;
        push       = (state_q == ST_WAIT) && imem_resp_valid && !redirect_valid;
        pop        = head_valid && dec_ready;
    end

    // Sequencer next state; a redirect overrides every other transition.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            case (state_q)
                ST_WAIT, ST_DROP: state_d = imem_resp_valid ? ST_REQ : ST_DROP;
                default:          state_d = fetch_enable ? ST_REQ : ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fetch_enable) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_fire) begin
                        state_d       = ST_WAIT;
                        inflight_pc_d = pc_q;
                        pc_d          = pc_q + ADDR_W'(1);
                    end else if (!fetch_enable) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT, ST_DROP: begin
                    if (imem_resp_valid) begin
                        state_d = fetch_enable ? ST_REQ : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Decode queue bookkeeping; redirect flushes all entries.
    always_comb begin
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = '{instr: imem_resp_data, pc: inflight_pc_q};
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fifo_q        <= fifo_d;
        end
    end

    always_comb begin
        estado_pc      = pc_q;
        imem_req_valid = req_valid;
        imem_req_addr  = pc_q;
        dec_valid      = head_valid;
        dec_instr      = fifo_q[rd_ptr_q].instr;
        dec_pc         = fifo_q[rd_ptr_q].pc;
    end

endmodule
